// File: rtl/and_gate_bist_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : and_bist_pkg
// Purpose  : Shared types, constants and the golden AND function for the
//            AND-gate built-in self-test sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package and_bist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int         NUM_VECTORS = 4;
    localparam logic [1:0] LAST_VEC    = 2'(NUM_VECTORS - 1);
    localparam logic [2:0] ERR_MAX     = 3'(NUM_VECTORS);

    // Golden response of a 2-input AND gate for vector {a,b}.
    function automatic logic exp_c(input logic [1:0] v);
        return v[1] & v[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/and_gate_bist_ctrl_settle_timer.sv
`default_nettype none
// ============================================================================
// Module   : settle_timer
// Purpose  : Down-counter that holds each stimulus vector for a programmable
//            number of cycles. Load has priority over decrement; the counter
//            stops at zero and flags it combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module settle_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] r_cnt;

    // Load a fresh settle count or step it down toward zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/and_gate_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : and_gate_bist_ctrl
// Purpose  : Self-test sequencer for a 2-input AND gate. Walks vectors
//            00,01,10,11, holds each for SETTLE_CYCLES, samples the gate
//            output, and scores mismatches and the first failing vector.
// Revision : 1.0 - initial release
// ============================================================================
module and_gate_bist_ctrl
    import and_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       dut_a,
    output logic       dut_b,
    input  logic       dut_c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [1:0] first_fail_vec,
    output logic       first_fail_valid
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_e     r_state;
    logic [1:0] r_vec;
    logic       r_dut_a;
    logic       r_dut_b;
    logic       r_busy;
    logic       r_done;
    logic [2:0] r_err_count;
    logic [1:0] r_first_fail_vec;
    logic       r_first_fail_valid;

    logic w_idle_or_done;
    logic w_launch;
    logic w_load;
    logic w_dec;
    logic w_zero;

    // Timer is (re)loaded when a run launches and when moving to the next
    // vector; it only counts while settling. Abort suppresses both.
    always_comb begin
        w_idle_or_done = (r_state == IDLE) || (r_state == DONE);
        w_launch       = w_idle_or_done && start && !abort;
        w_load         = w_launch ||
                         ((r_state == SAMPLE) && !abort && (r_vec != LAST_VEC));
        w_dec          = (r_state == SETTLE) && !abort && !w_zero;
    end

    settle_timer #(
        .CNT_W (CNT_W)
    ) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .load_val (SETTLE_LOAD),
        .dec      (w_dec),
        .zero     (w_zero)
    );

    // Sequencer FSM with registered stimulus, status and score outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state            <= IDLE;
            r_vec              <= 2'b00;
            r_dut_a            <= 1'b0;
            r_dut_b            <= 1'b0;
            r_busy             <= 1'b0;
            r_done             <= 1'b0;
            r_err_count        <= 3'd0;
            r_first_fail_vec   <= 2'b00;
            r_first_fail_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (abort) begin
                        // Abort wins over start; from DONE it also clears done.
                        r_state <= IDLE;
                        r_done  <= 1'b0;
                    end else if (start) begin
                        r_state            <= SETTLE;
                        r_vec              <= 2'b00;
                        r_dut_a            <= 1'b0;
                        r_dut_b            <= 1'b0;
                        r_busy             <= 1'b1;
                        r_done             <= 1'b0;
                        r_err_count        <= 3'd0;
                        r_first_fail_vec   <= 2'b00;
                        r_first_fail_valid <= 1'b0;
                    end
                end

                SETTLE: begin
                    if (abort) begin
                        // Scores are kept on abort so the partial run can be inspected.
                        r_state <= IDLE;
                        r_dut_a <= 1'b0;
                        r_dut_b <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end else if (w_zero) begin
                        r_state <= SAMPLE;
                    end
                end

                SAMPLE: begin
                    if (abort) begin
                        r_state <= IDLE;
                        r_dut_a <= 1'b0;
                        r_dut_b <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end else begin
                        if (dut_c != exp_c(r_vec)) begin
                            if (r_err_count != ERR_MAX) begin
                                r_err_count <= r_err_count + 3'd1;
                            end
                            if (!r_first_fail_valid) begin
                                r_first_fail_vec   <= r_vec;
                                r_first_fail_valid <= 1'b1;
                            end
                        end
                        if (r_vec == LAST_VEC) begin
                            r_state <= DONE;
                            r_dut_a <= 1'b0;
                            r_dut_b <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= SETTLE;
                            r_vec   <= r_vec + 2'd1;
                            {r_dut_a, r_dut_b} <= r_vec + 2'd1;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign dut_a            = r_dut_a;
    assign dut_b            = r_dut_b;
    assign busy             = r_busy;
    assign done             = r_done;
    assign err_count        = r_err_count;
    assign first_fail_vec   = r_first_fail_vec;
    assign first_fail_valid = r_first_fail_valid;
    assign pass             = r_done && (r_err_count == 3'd0);

endmodule
`default_nettype wire

// File: tb/tb_and_gate_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_and_gate_bist_ctrl
// Purpose  : Self-checking bench for the AND-gate BIST sequencer. The gate is
//            modelled beside the DUT with selectable stuck-at faults; expected
//            timing and scores come from a vector-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_and_gate_bist_ctrl;

    localparam int SETTLE    = 2;
    localparam int S1        = SETTLE + 1;
    localparam int NVEC      = 4;
    localparam int LAST_EDGE = NVEC * S1;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       dut_a;
    logic       dut_b;
    logic       dut_c;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [1:0] first_fail_vec;
    logic       first_fail_valid;

    int fault_mode;   // 0 good gate, 1 output stuck-at-1, 2 output stuck-at-0
    int n_assert;
    int n_fail;

    // AND gate under test, with forced output faults.
    assign dut_c = (fault_mode == 1) ? 1'b1 :
                   (fault_mode == 2) ? 1'b0 : (dut_a & dut_b);

    and_gate_bist_ctrl #(
        .SETTLE_CYCLES (SETTLE),
        .CNT_W         (8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .abort            (abort),
        .dut_a            (dut_a),
        .dut_b            (dut_b),
        .dut_c            (dut_c),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_count        (err_count),
        .first_fail_vec   (first_fail_vec),
        .first_fail_valid (first_fail_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200us");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: score the first nvec vectors of a run against the AND truth
    // table (only {1,1} yields 1), given what the faulty gate would output.
    function automatic void model(input int fault, input int nvec,
                                  output int err, output logic [1:0] ffv,
                                  output logic ffok);
        err  = 0;
        ffv  = 2'b00;
        ffok = 1'b0;
        for (int k = 0; k < nvec; k++) begin
            int want;
            int got;
            want = (k == NVEC - 1) ? 1 : 0;
            got  = (fault == 1) ? 1 : (fault == 2) ? 0 : want;
            if (got != want) begin
                if (err < 4) err++;
                if (!ffok) begin
                    ffok = 1'b1;
                    ffv  = 2'(k);
                end
            end
        end
    endfunction

    task automatic chk_scores(input string tag, input int fault, input int nvec);
        int         e_err;
        logic [1:0] e_ffv;
        logic       e_ffok;
        model(fault, nvec, e_err, e_ffv, e_ffok);
        chk({tag, "/err_count"}, 8'(err_count), 8'(e_err));
        chk({tag, "/ff_valid"}, 8'(first_fail_valid), 8'(e_ffok));
        if (e_ffok) chk({tag, "/ff_vec"}, 8'(first_fail_vec), 8'(e_ffv));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "/dut_ab"}, 8'({dut_a, dut_b}), 8'd0);
        chk({tag, "/busy"}, 8'(busy), 8'd0);
        chk({tag, "/done"}, 8'(done), 8'd0);
        chk({tag, "/pass"}, 8'(pass), 8'd0);
        chk({tag, "/err_count"}, 8'(err_count), 8'd0);
        chk({tag, "/ff_vec"}, 8'(first_fail_vec), 8'd0);
        chk({tag, "/ff_valid"}, 8'(first_fail_valid), 8'd0);
    endtask

    // One run: start sampled at edge 0, optional abort sampled at abort_edge
    // (1..LAST_EDGE mid-run, >LAST_EDGE one edge after done, 0 none).
    task automatic run_check(input string tag, input int fault,
                             input int abort_edge, input bit hold);
        int         e_err;
        logic [1:0] e_ffv;
        logic       e_ffok;
        fault_mode = fault;
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        for (int e = 1; e <= LAST_EDGE; e++) begin
            chk({tag, "/busy"}, 8'(busy), 8'd1);
            chk({tag, "/done"}, 8'(done), 8'd0);
            chk({tag, "/dut_ab"}, 8'({dut_a, dut_b}), 8'((e - 1) / S1));
            if (e == abort_edge) abort = 1'b1;
            tick();
            if (e == abort_edge) begin
                abort = 1'b0;
                chk({tag, "/abort_busy"}, 8'(busy), 8'd0);
                chk({tag, "/abort_done"}, 8'(done), 8'd0);
                chk({tag, "/abort_pass"}, 8'(pass), 8'd0);
                chk({tag, "/abort_dut_ab"}, 8'({dut_a, dut_b}), 8'd0);
                chk_scores({tag, "/abort"}, fault, (e - 1) / S1);
                return;
            end
        end
        model(fault, NVEC, e_err, e_ffv, e_ffok);
        chk({tag, "/end_busy"}, 8'(busy), 8'd0);
        chk({tag, "/end_done"}, 8'(done), 8'd1);
        chk({tag, "/end_pass"}, 8'(pass), 8'(e_err == 0));
        chk({tag, "/end_dut_ab"}, 8'({dut_a, dut_b}), 8'd0);
        chk_scores({tag, "/end"}, fault, NVEC);
        if (abort_edge > LAST_EDGE) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            chk({tag, "/dabort_done"}, 8'(done), 8'd0);
            chk({tag, "/dabort_pass"}, 8'(pass), 8'd0);
            chk({tag, "/dabort_busy"}, 8'(busy), 8'd0);
            chk_scores({tag, "/dabort"}, fault, NVEC);
        end
    endtask

    initial begin
        int f;
        int ae;
        n_assert   = 0;
        n_fail     = 0;
        fault_mode = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) tick();
        chk_all_zero("idle");

        // 1: good gate
        run_check("good", 0, 0, 1'b0);
        chk("good/pass_const", 8'(pass), 8'd1);

        // 2: stuck-at-1 fails 00,01,10
        run_check("sa1", 1, 0, 1'b0);
        chk("sa1/err_const", 8'(err_count), 8'd3);
        chk("sa1/ffv_const", 8'(first_fail_vec), 8'd0);

        // 3: stuck-at-0 fails only 11
        run_check("sa0", 2, 0, 1'b0);
        chk("sa0/err_const", 8'(err_count), 8'd1);
        chk("sa0/ffv_const", 8'(first_fail_vec), 8'd3);

        // 4: abort while vector 01 is in flight, then a fresh passing run
        run_check("abort", 0, 6, 1'b0);
        run_check("after_abort", 0, 0, 1'b0);

        // start and abort together from DONE: abort wins, no run
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort/busy", 8'(busy), 8'd0);
        chk("start_abort/done", 8'(done), 8'd0);
        tick();
        chk("start_abort/busy2", 8'(busy), 8'd0);

        // 5: start held through a run, then restart from DONE
        run_check("hold1", 0, 0, 1'b1);
        run_check("hold2", 0, 0, 1'b0);

        // 6: async reset mid-run
        fault_mode = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        chk("prereset/busy", 8'(busy), 8'd1);
        chk("prereset/err", 8'(err_count), 8'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        tick();
        rst_n = 1'b1;
        tick();
        chk_all_zero("post_reset");
        run_check("post_reset_run", 0, 0, 1'b0);

        // Randomized runs: fault mode and abort point drawn at random
        for (int i = 0; i < 10; i++) begin
            f  = int'($urandom_range(0, 2));
            ae = int'($urandom_range(0, LAST_EDGE + 3));
            if (ae > LAST_EDGE) ae = LAST_EDGE + 1;
            run_check($sformatf("rand%0d_f%0d_a%0d", i, f, ae), f, ae, 1'b0);
            repeat (int'($urandom_range(0, 3))) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
